// File: rtl/acc_alu_pkg.sv
// Shared opcode and FSM state encodings for the accumulator ALU.
package acc_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_NOT   = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_MUL   = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: bit 0 of b is consumed on load,
// the remaining WIDTH-1 bits one per cycle while busy is high.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
            cnt    <= CW'(WIDTH - 1);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    assign busy    = (cnt != '0);
    assign product = prod;

endmodule

// File: rtl/acc_alu.sv
// Multi-cycle accumulator ALU driving an attached register file.
// ACC_ALU_MUL_EN adds the iterative MUL opcode; without it opcode 11 is a NOP.
module acc_alu
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [OP_W-1:0]          op,
    input  logic [$clog2(N_REG)-1:0] reg_sel,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_REG)-1:0] rf_a,
    output logic                     rf_ce,
    output logic [WIDTH-1:0]         rf_in,
    input  logic [WIDTH-1:0]         rf_out,
    output logic [WIDTH-1:0]         acc,
    output logic                     flag_z,
    output logic                     flag_c
);

    localparam int AW = $clog2(N_REG);
    localparam logic [AW-1:0] USER_REG = AW'(N_REG - 1);

    state_e state, state_nxt;
    op_e    op_q;

    logic [WIDTH-1:0] alu_acc;
    logic             alu_c;
    logic             alu_z;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, rf_out};

`ifdef ACC_ALU_MUL_EN
    logic               mul_busy;
    logic [2*WIDTH-1:0] mul_prod;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (state == S_EXEC && op_q == OP_MUL),
        .a       (acc),
        .b       (rf_out),
        .busy    (mul_busy),
        .product (mul_prod)
    );
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        alu_acc = acc;
        alu_c   = flag_c;
        alu_z   = flag_z;
        case (op_q)
            OP_LOAD: begin alu_acc = rf_out; alu_c = 1'b0; end
            OP_ADD:  {alu_c, alu_acc} = sum;
            OP_SUB:  begin alu_acc = acc - rf_out; alu_c = (acc < rf_out); end
            OP_AND:  alu_acc = acc & rf_out;
            OP_OR:   alu_acc = acc | rf_out;
            OP_XOR:  alu_acc = acc ^ rf_out;
            OP_NOT:  alu_acc = ~acc;
            OP_SHL:  {alu_c, alu_acc} = {acc, 1'b0};
            OP_SHR:  {alu_acc, alu_c} = {1'b0, acc};
            default: ;
        endcase
        case (op_q)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL, OP_SHR: alu_z = (alu_acc == '0);
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_EXEC;
`ifdef ACC_ALU_MUL_EN
            S_EXEC: state_nxt = (op_q == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (!mul_busy) state_nxt = S_DONE;
`else
            S_EXEC: state_nxt = S_DONE;
            S_MUL:  state_nxt = S_IDLE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the synchronous reset clears every register here, datapath
    // included, because an aborted op must leave acc and flags at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            rf_a   <= '0;
            acc    <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                op_q <= op_e'(op);
                rf_a <= reg_sel;
            end
            if (state == S_EXEC) begin
                acc    <= alu_acc;
                flag_z <= alu_z;
                flag_c <= alu_c;
            end
`ifdef ACC_ALU_MUL_EN
            if (state == S_MUL && !mul_busy) begin
                acc    <= mul_prod[WIDTH-1:0];
                flag_c <= |mul_prod[2*WIDTH-1:WIDTH];
                flag_z <= (mul_prod[WIDTH-1:0] == '0);
            end
`endif
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign rf_in = acc;
    // Gated by rst so an op aborted during EXEC never writes the register file.
    assign rf_ce = !rst && (state == S_EXEC) && (op_q == OP_STORE) && (rf_a != USER_REG);

endmodule

// File: tb/tb_acc_alu.sv
// Directed self-checking bench for acc_alu with a register file model attached.
module tb_acc_alu;
    import acc_alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [2:0] reg_sel;
    logic       busy;
    logic       done;
    logic [2:0] rf_a;
    logic       rf_ce;
    logic [7:0] rf_in;
    logic [7:0] rf_out;
    logic [7:0] acc;
    logic       flag_z;
    logic       flag_c;

    logic [7:0] regs [0:7];
    logic [7:0] user_in;
    logic       poke_en;
    logic [2:0] poke_addr;
    logic [7:0] poke_data;

    int n_checks;
    int n_pass;
    int done_count;
    int ce_count;
    logic [2:0] ce_a;
    logic [7:0] ce_in;

    acc_alu #(.WIDTH(8), .N_REG(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .reg_sel (reg_sel),
        .busy    (busy),
        .done    (done),
        .rf_a    (rf_a),
        .rf_ce   (rf_ce),
        .rf_in   (rf_in),
        .rf_out  (rf_out),
        .acc     (acc),
        .flag_z  (flag_z),
        .flag_c  (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_out = (rf_a == 3'd7) ? user_in : regs[rf_a];

    always @(posedge clk) begin
        if (poke_en) regs[poke_addr] <= poke_data;
        else if (rf_ce && rf_a != 3'd7) regs[rf_a] <= rf_in;
    end

    initial begin
        done_count = 0;
        ce_count   = 0;
        ce_a       = '0;
        ce_in      = '0;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (rf_ce === 1'b1) begin
            ce_count++;
            ce_a  = rf_a;
            ce_in = rf_in;
        end
    end

    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Issues one op from IDLE and returns in the DONE cycle (lat = cycles after accept).
    task automatic run_op(input logic [3:0] o, input logic [2:0] sel, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        start = 1'b1; op = o; reg_sel = sel;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (acc !== 8'h00) $display("FAIL reset_acc: got %h want 00", acc); else n_pass++;
        n_checks++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {flag_z, flag_c}); else n_pass++;
        n_checks++; if ({busy, done, rf_ce} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, done, rf_ce}); else n_pass++;
        n_checks++; if (rf_a !== 3'd0) $display("FAIL reset_rf_a: got %0d want 0", rf_a); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_load_user;
        int lat, ce0;
        user_in = 8'h5A;
        ce0 = ce_count;
        run_op(OP_LOAD, 3'd7, lat);
        n_checks++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (acc !== 8'h5A) $display("FAIL load_acc: got %h want 5a", acc); else n_pass++;
        n_checks++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL load_flags: got %b want 00", {flag_z, flag_c}); else n_pass++;
        n_checks++; if (rf_in !== 8'h5A) $display("FAIL load_rf_in: got %h want 5a", rf_in); else n_pass++;
        n_checks++; if (ce_count - ce0 !== 0) $display("FAIL load_no_write: got %0d writes want 0", ce_count - ce0); else n_pass++;
    endtask

    task automatic test_arith;
        int lat;
        set_reg(3'd0, 8'hF0); set_reg(3'd1, 8'h20);
        run_op(OP_LOAD, 3'd0, lat);
        run_op(OP_ADD, 3'd1, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h10, 1'b1, 1'b0}) $display("FAIL add_carry: got acc=%h c=%b z=%b want 10 1 0", acc, flag_c, flag_z); else n_pass++;
        set_reg(3'd0, 8'h33); set_reg(3'd2, 8'h33);
        run_op(OP_LOAD, 3'd0, lat);
        run_op(OP_SUB, 3'd2, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h00, 1'b0, 1'b1}) $display("FAIL sub_zero: got acc=%h c=%b z=%b want 00 0 1", acc, flag_c, flag_z); else n_pass++;
        set_reg(3'd0, 8'h01); set_reg(3'd2, 8'h02);
        run_op(OP_LOAD, 3'd0, lat);
        run_op(OP_SUB, 3'd2, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'hFF, 1'b1, 1'b0}) $display("FAIL sub_borrow: got acc=%h c=%b z=%b want ff 1 0", acc, flag_c, flag_z); else n_pass++;
        run_op(OP_AND, 3'd1, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h20, 1'b1, 1'b0}) $display("FAIL and: got acc=%h c=%b z=%b want 20 1 0", acc, flag_c, flag_z); else n_pass++;
        run_op(OP_OR, 3'd2, lat);
        n_checks++; if (acc !== 8'h22) $display("FAIL or: got %h want 22", acc); else n_pass++;
        run_op(OP_XOR, 3'd1, lat);
        n_checks++; if (acc !== 8'h02) $display("FAIL xor: got %h want 02", acc); else n_pass++;
        run_op(OP_NOT, 3'd1, lat);
        n_checks++; if ({acc, flag_c} !== {8'hFD, 1'b1}) $display("FAIL not: got acc=%h c=%b want fd 1", acc, flag_c); else n_pass++;
        run_op(OP_SHL, 3'd1, lat);
        n_checks++; if ({acc, flag_c} !== {8'hFA, 1'b1}) $display("FAIL shl: got acc=%h c=%b want fa 1", acc, flag_c); else n_pass++;
        run_op(OP_SHR, 3'd1, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h7D, 1'b0, 1'b0}) $display("FAIL shr: got acc=%h c=%b z=%b want 7d 0 0", acc, flag_c, flag_z); else n_pass++;
        run_op(OP_NOP, 3'd1, lat);
        n_checks++; if ({acc, flag_c, lat} !== {8'h7D, 1'b0, 32'd2}) $display("FAIL nop: got acc=%h c=%b lat=%0d want 7d 0 2", acc, flag_c, lat); else n_pass++;
        run_op(4'd12, 3'd1, lat);
        n_checks++; if ({acc, lat} !== {8'h7D, 32'd2}) $display("FAIL op12_nop: got acc=%h lat=%0d want 7d 2", acc, lat); else n_pass++;
    endtask

    task automatic test_store;
        int lat, ce0;
        set_reg(3'd0, 8'hA5); set_reg(3'd3, 8'h00);
        run_op(OP_LOAD, 3'd0, lat);
        ce0 = ce_count;
        run_op(OP_STORE, 3'd3, lat);
        n_checks++; if (ce_count - ce0 !== 1) $display("FAIL store_ce_cycles: got %0d want 1", ce_count - ce0); else n_pass++;
        n_checks++; if ({ce_a, ce_in} !== {3'd3, 8'hA5}) $display("FAIL store_bus: got a=%0d in=%h want 3 a5", ce_a, ce_in); else n_pass++;
        n_checks++; if ({acc, lat} !== {8'hA5, 32'd2}) $display("FAIL store_acc: got acc=%h lat=%0d want a5 2", acc, lat); else n_pass++;
        set_reg(3'd0, 8'h00);
        run_op(OP_LOAD, 3'd0, lat);
        run_op(OP_LOAD, 3'd3, lat);
        n_checks++; if (acc !== 8'hA5) $display("FAIL store_readback: got %h want a5", acc); else n_pass++;
        ce0 = ce_count;
        run_op(OP_STORE, 3'd7, lat);
        n_checks++; if (lat !== 2) $display("FAIL store_r7_done: got lat %0d want 2", lat); else n_pass++;
        @(negedge clk);
        n_checks++; if (ce_count - ce0 !== 0) $display("FAIL store_r7_ro: got %0d writes want 0", ce_count - ce0); else n_pass++;
    endtask

    task automatic test_mul;
        int lat;
        set_reg(3'd0, 8'h12); set_reg(3'd4, 8'h10);
        run_op(OP_LOAD, 3'd0, lat);
        run_op(OP_MUL, 3'd4, lat);
`ifdef ACC_ALU_MUL_EN
        n_checks++; if (lat !== 10) $display("FAIL mul_latency: got %0d want 10", lat); else n_pass++;
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h20, 1'b1, 1'b0}) $display("FAIL mul_result: got acc=%h c=%b z=%b want 20 1 0", acc, flag_c, flag_z); else n_pass++;
        set_reg(3'd5, 8'h0B);
        run_op(OP_MUL, 3'd5, lat);
        n_checks++; if ({acc, flag_c, flag_z} !== {8'h60, 1'b1, 1'b0}) $display("FAIL mul_odd: got acc=%h c=%b z=%b want 60 1 0", acc, flag_c, flag_z); else n_pass++;
`else
        n_checks++; if (lat !== 2) $display("FAIL mul_nop_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if ({acc, flag_c} !== {8'h12, 1'b0}) $display("FAIL mul_nop_acc: got acc=%h c=%b want 12 0", acc, flag_c); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back;
        int d0;
        user_in = 8'h3C;
        @(negedge clk);
        while (busy === 1'b1) @(negedge clk);
        d0 = done_count;
        start = 1'b1; op = OP_LOAD; reg_sel = 3'd7;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (done_count - d0 !== 1) $display("FAIL busy_start_ignored: got %0d dones want 1", done_count - d0); else n_pass++;
        n_checks++; if ({acc, busy} !== {8'h3C, 1'b0}) $display("FAIL busy_start_acc: got acc=%h busy=%b want 3c 0", acc, busy); else n_pass++;
    endtask

    task automatic test_abort;
        int lat, d0, ce0;
        set_reg(3'd5, 8'h77);
        d0 = done_count; ce0 = ce_count;
        @(negedge clk);
        start = 1'b1; op = OP_STORE; reg_sel = 3'd5;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if ({busy, acc} !== {1'b0, 8'h00}) $display("FAIL abort_store_state: got busy=%b acc=%h want 0 00", busy, acc); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if ({ce_count - ce0, done_count - d0, regs[5]} !== {32'd0, 32'd0, 8'h77}) $display("FAIL abort_store_nowrite: got ce=%0d done=%0d r5=%h want 0 0 77", ce_count - ce0, done_count - d0, regs[5]); else n_pass++;
`ifdef ACC_ALU_MUL_EN
        set_reg(3'd0, 8'h12); set_reg(3'd4, 8'h10);
        run_op(OP_LOAD, 3'd0, lat);
        @(negedge clk);
        d0 = done_count;
        start = 1'b1; op = OP_MUL; reg_sel = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if ({busy, done, acc, flag_c} !== {1'b0, 1'b0, 8'h00, 1'b0}) $display("FAIL abort_mul_state: got busy=%b done=%b acc=%h c=%b want 0 0 00 0", busy, done, acc, flag_c); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (done_count - d0 !== 0) $display("FAIL abort_mul_nodone: got %0d dones want 0", done_count - d0); else n_pass++;
`endif
        user_in = 8'h5A;
        run_op(OP_LOAD, 3'd7, lat);
        n_checks++; if ({lat, acc} !== {32'd2, 8'h5A}) $display("FAIL after_abort_load: got lat=%0d acc=%h want 2 5a", lat, acc); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = '0;
        reg_sel   = '0;
        user_in   = 8'h00;
        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        test_reset;
        test_load_user;
        test_arith;
        test_store;
        test_mul;
        test_back_to_back;
        test_abort;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_alu.md
Name: acc_alu

Overview:
- Multi-cycle accumulator ALU that sits directly downstream of the register file and also writes back into it.
- Drives the register file's address/write-enable/write-data and consumes its combinational read data.
- Each operation is requested with a start/op/reg_sel handshake; completion is signalled by a one-cycle done pulse.
- Holds the accumulator and the Z/C flags for the simple lab CPU datapath.

Parameters:
- WIDTH, 8, datapath, accumulator and register width.
- N_REG, 8, register count in the attached register file. Register N_REG-1 is the external read-only user-input register.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  4  opcode, sampled with start
- reg_sel  in  $clog2(N_REG)  operand/destination register, sampled with start
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle completion pulse
- rf_a  out  $clog2(N_REG)  register file address (latched reg_sel)
- rf_ce  out  1  register file write enable
- rf_in  out  WIDTH  register file write data; always equals acc
- rf_out  in  WIDTH  register file combinational read data
- acc  out  WIDTH  accumulator
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag

Behaviour:
- Reset values: state=IDLE, acc=0, flag_z=0, flag_c=0, rf_a=0, rf_ce=0, busy=0, done=0.
- rst mid-operation aborts the operation, discards it and applies the reset values on the next edge. No write is issued.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, 10 SHR, 11 MUL. Opcodes 12-15 behave as NOP.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - On start=1, latch op and reg_sel (rf_a <= reg_sel), then go to EXEC.
  - start while not in IDLE is ignored; it is not queued.
- EXEC (one cycle): operand = rf_out, which is combinational from the latched rf_a. Result is registered at the end of the cycle, then go to DONE, except MUL, which goes to MUL.
- MUL: iterative shift-add, one multiplier bit per cycle, WIDTH cycles, then go to DONE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. start can be accepted in the following IDLE cycle.
- Latency, with start accepted at edge 0:
  - done is high in cycle 2 for all non-MUL ops.
  - done is high in cycle 2+WIDTH for MUL.
  - acc and flags are valid while done is high.
- Arithmetic (all results truncated to WIDTH):
  - LOAD: acc=R; C=0.
  - ADD: {C,acc} = acc+R, computed WIDTH+1 wide.
  - SUB: acc = acc-R; C = borrow (acc<R unsigned).
  - AND/OR/XOR: bitwise with R; C unchanged.
  - NOT: acc = ~acc; C unchanged.
  - SHL: C = acc[WIDTH-1]; acc = acc<<1. SHR: C = acc[0]; acc = acc>>1. Both ignore R.
  - MUL: acc = low WIDTH bits of acc*R (unsigned); C = OR of the high WIDTH bits.
  - Z = (new acc == 0) for every op that writes acc.
  - NOP and STORE leave acc, Z and C unchanged.
- STORE:
  - rf_ce=1 for exactly the EXEC cycle, so the register is written at the EXEC→DONE edge with rf_in=acc.
  - If rf_a == N_REG-1, rf_ce stays 0 (external register is read-only); done still pulses.
- rf_ce is 0 in every other state and for every other op.

Optional Feature:
- Macro: ACC_ALU_MUL_EN.
- Defined: MUL state and the multiplier are present, with behaviour as above.
- Undefined: no multiplier logic; opcode 11 behaves as NOP with 2-cycle latency; the MUL state is unreachable and may be omitted.

Decomposition:
- Package acc_alu_pkg holds:
  - OP_W=4
  - opcode enum op_e (OP_NOP..OP_MUL)
  - state enum state_e (S_IDLE, S_EXEC, S_MUL, S_DONE)
- One sub-module, shift_add_mul (WIDTH parameter; ports clk, rst, load, a, b, busy/last, product 2*WIDTH).
  - Instantiated only under ACC_ALU_MUL_EN.
  - Shares rst with acc_alu, so a reset aborts it too.

Test Plan (WIDTH=8, N_REG=8, attached to register file model):
- rst; user_in=0x5A; start LOAD r7 → done in cycle 2, acc=0x5A, Z=0, C=0, rf_ce never 1.
- acc=0xF0, r1=0x20; ADD r1 → acc=0x10, C=1, Z=0. Then acc=0x33, r2=0x33; SUB r2 → acc=0x00, Z=1, C=0. Then acc=0x01, r2=0x02; SUB r2 → acc=0xFF, C=1.
- acc=0xA5; STORE r3 → rf_ce=1 for one cycle with a=3, in=0xA5. LOAD r3 → acc=0xA5. STORE r7 → rf_ce stays 0, done pulses.
- ACC_ALU_MUL_EN defined: acc=0x12, r4=0x10; MUL r4 → done in cycle 10, acc=0x20, C=1, Z=0.
- ACC_ALU_MUL_EN undefined: same stimulus → done in cycle 2, acc=0x12 unchanged.
- start pulsed while busy → ignored (one done only). rst asserted at MUL cycle 4 → next cycle IDLE, acc=0, busy=0, done never pulses. A following start LOAD r7 completes normally.
